// File: rtl/lpc_pkg.sv
// lpc_pkg: definitions shared by the LPC host and the passive LPC decoder.
//   lpc_state_t    - host FSM states (also exported on the host debug port)
//   CYC_*, DIR_BIT - CYCTYPE field values and the direction bit index
//   SYNC_*         - SYNC nibble codes driven by a target
//   LAD_*          - host-driven START and ABORT nibbles
//   cyc_supported  - true for the cycle types this host can run (io, mem)
package lpc_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        CYCDIR,
        ADDR,
        WDATA,
        TAR,
        SYNC,
        RDATA,
        TAREND,
        RESP,
        ABORT
    } lpc_state_t;

    localparam logic [1:0] CYC_IO  = 2'b00;
    localparam logic [1:0] CYC_MEM = 2'b01;
    localparam int         DIR_BIT = 1;     // 0 = read, 1 = write

    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_SHORT = 4'b0101;
    localparam logic [3:0] SYNC_LONG  = 4'b0110;
    localparam logic [3:0] SYNC_ERR   = 4'b1010;
    localparam logic [3:0] SYNC_NONE  = 4'b1111;

    localparam logic [3:0] LAD_START = 4'b0000;
    localparam logic [3:0] LAD_ABORT = 4'b1111;

    function automatic logic cyc_supported(input logic [3:0] cyctype_dir);
        return (cyctype_dir[3:2] == CYC_IO) || (cyctype_dir[3:2] == CYC_MEM);
    endfunction

endpackage

// File: rtl/lpc_host_if.sv
// lpc_host_if: request/response handshake plus LAD/LFRAME# pad signals of
// the LPC host.
//   master - the host (lpc_host) view
//   slave  - the requester / pad / target view
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only while the host is idle.
// Completion is a single-cycle rsp_valid pulse with no back-pressure;
// rsp_rdata and rsp_error are meaningful only while rsp_valid is high.
interface lpc_host_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cyctype_dir;
    logic [31:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_error;
    logic [3:0]  lpc_ad_out;
    logic        lpc_ad_oe;
    logic [3:0]  lpc_ad_in;
    logic        lpc_frame;

    modport master (
        input  req_valid, req_cyctype_dir, req_addr, req_wdata, lpc_ad_in,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
               lpc_ad_out, lpc_ad_oe, lpc_frame
    );

    modport slave (
        output req_valid, req_cyctype_dir, req_addr, req_wdata, lpc_ad_in,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
               lpc_ad_out, lpc_ad_oe, lpc_frame
    );
endinterface

// File: rtl/lpc_sync_eval.sv
// lpc_sync_eval: classifies the SYNC nibble sampled from LAD and keeps the
// wait and no-response counters while the host sits in SYNC.
//   clk, rst_n - clock, async active-low reset
//   active     - host is in SYNC; counters are held at zero otherwise
//   ad_in      - sampled LAD nibble
//   ready      - leave SYNC and continue the cycle (READY or ERR code)
//   err        - the target reported an error SYNC
//   abort      - illegal code, no-response timeout or wait limit reached
module lpc_sync_eval
    import lpc_pkg::*;
#(
    parameter int SYNC_TIMEOUT = 4,
    parameter int WAIT_MAX     = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       active,
    input  logic [3:0] ad_in,
    output logic       ready,
    output logic       err,
    output logic       abort
);

    localparam int NW = $clog2(SYNC_TIMEOUT + 1);
    localparam int WW = $clog2(WAIT_MAX + 1);

    logic [NW-1:0] none_cnt;
    logic [WW-1:0] wait_cnt;
    logic          none_hit;
    logic          wait_hit;

    // Limits are checked against the count including the current cycle.
    assign none_hit = (32'(none_cnt) + 32'd1) >= 32'(SYNC_TIMEOUT);
    assign wait_hit = (32'(wait_cnt) + 32'd1) >= 32'(WAIT_MAX);

    always_comb begin
        ready = 1'b0;
        err   = 1'b0;
        abort = 1'b0;
        if (active) begin
            case (ad_in)
                SYNC_READY:            ready = 1'b1;
                SYNC_ERR:              begin ready = 1'b1; err = 1'b1; end
                SYNC_SHORT, SYNC_LONG: abort = wait_hit;
                SYNC_NONE:             abort = none_hit;
                default:               abort = 1'b1;
            endcase
        end
    end

    // The wait count is a total over the whole SYNC phase; the no-response
    // count only tracks an unbroken run of 1111.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            none_cnt <= '0;
            wait_cnt <= '0;
        end else if (!active) begin
            none_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            case (ad_in)
                SYNC_SHORT, SYNC_LONG: begin
                    wait_cnt <= wait_cnt + WW'(1);
                    none_cnt <= '0;
                end
                SYNC_NONE: none_cnt <= none_cnt + NW'(1);
                default:   none_cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/lpc_host.sv
// lpc_host: LPC 1.1 initiator. Runs one single-byte io/mem read or write
// per request on LAD[3:0]/LFRAME#, handles SYNC waits, timeout and abort,
// and returns read data and status as a one-cycle response.
//   lpc_clock - LPC clock, rising edge
//   lpc_reset - async active-low reset; drops any cycle in flight
//   bus       - lpc_host_if.master (request, response, LAD out/oe/in, frame)
//   state     - current FSM state for debug
module lpc_host
    import lpc_pkg::*;
#(
    parameter int SYNC_TIMEOUT = 4,
    parameter int WAIT_MAX     = 255
) (
    input  logic       lpc_clock,
    input  logic       lpc_reset,
    lpc_host_if.master bus,
    output lpc_state_t state
);

    lpc_state_t  state_next;
    logic [2:0]  cnt;        // cycle index within the current state
    logic [3:0]  cyc_q;
    logic [31:0] addr_sh;    // next address nibble always sits in [31:28]
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        err_q;
    logic        is_read;
    logic        is_mem;
    logic        sync_ready;
    logic        sync_err;
    logic        sync_abort;

    logic        frame;
    logic        ad_oe;
    logic [3:0]  ad_out;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_error;
    logic [7:0]  rsp_rdata;

    assign is_read = ~cyc_q[DIR_BIT];
    assign is_mem  = (cyc_q[3:2] == CYC_MEM);

    lpc_sync_eval #(
        .SYNC_TIMEOUT (SYNC_TIMEOUT),
        .WAIT_MAX     (WAIT_MAX)
    ) u_sync_eval (
        .clk    (lpc_clock),
        .rst_n  (lpc_reset),
        .active (state == SYNC),
        .ad_in  (bus.lpc_ad_in),
        .ready  (sync_ready),
        .err    (sync_err),
        .abort  (sync_abort)
    );

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (bus.req_valid)
                        state_next = cyc_supported(bus.req_cyctype_dir) ? START : RESP;
            START:  state_next = CYCDIR;
            CYCDIR: state_next = ADDR;
            ADDR:   if (cnt == (is_mem ? 3'd7 : 3'd3))
                        state_next = is_read ? TAR : WDATA;
            WDATA:  if (cnt == 3'd1) state_next = TAR;
            TAR:    if (cnt == 3'd1) state_next = SYNC;
            SYNC:   if (sync_abort)      state_next = ABORT;
                    else if (sync_ready) state_next = is_read ? RDATA : TAREND;
            RDATA:  if (cnt == 3'd1) state_next = TAREND;
            TAREND: if (cnt == 3'd1) state_next = RESP;
            RESP:   state_next = IDLE;
            ABORT:  if (cnt == 3'd3) state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        frame     = 1'b1;
        ad_oe     = 1'b0;
        ad_out    = LAD_ABORT;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_error = 1'b0;
        rsp_rdata = 8'h00;
        case (state)
            IDLE:   req_ready = 1'b1;
            START:  begin frame = 1'b0; ad_oe = 1'b1; ad_out = LAD_START; end
            CYCDIR: begin ad_oe = 1'b1; ad_out = cyc_q; end
            ADDR:   begin ad_oe = 1'b1; ad_out = addr_sh[31:28]; end
            WDATA:  begin ad_oe = 1'b1; ad_out = cnt[0] ? wdata_q[7:4] : wdata_q[3:0]; end
            TAR:    ad_oe = (cnt == 3'd0);   // drive 1111 once, then release
            RESP:   begin
                rsp_valid = 1'b1;
                rsp_error = err_q;
                rsp_rdata = err_q ? 8'h00 : rdata_q;
            end
            ABORT:  begin frame = 1'b0; ad_oe = 1'b1; ad_out = LAD_ABORT; end
            default: ;
        endcase
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            cnt     <= 3'd0;
            cyc_q   <= 4'h0;
            addr_sh <= 32'h0;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            cnt <= (state_next != state) ? 3'd0 : cnt + 3'd1;
            case (state)
                IDLE: if (bus.req_valid) begin
                    cyc_q   <= bus.req_cyctype_dir;
                    // io cycles send only the low 16 address bits
                    addr_sh <= (bus.req_cyctype_dir[3:2] == CYC_MEM) ? bus.req_addr
                                                                     : {bus.req_addr[15:0], 16'h0000};
                    wdata_q <= bus.req_wdata;
                    rdata_q <= 8'h00;
                    err_q   <= ~cyc_supported(bus.req_cyctype_dir);
                end
                ADDR:  addr_sh <= {addr_sh[27:0], 4'h0};
                SYNC:  if (sync_err || sync_abort) err_q <= 1'b1;
                RDATA: if (cnt == 3'd0) rdata_q[3:0] <= bus.lpc_ad_in;
                       else             rdata_q[7:4] <= bus.lpc_ad_in;
                default: ;
            endcase
        end
    end

    assign bus.lpc_frame  = frame;
    assign bus.lpc_ad_oe  = ad_oe;
    assign bus.lpc_ad_out = ad_out;
    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_error  = rsp_error;
    assign bus.rsp_rdata  = rsp_rdata;

endmodule

// File: tb/tb_lpc_host.sv
// tb_lpc_host: testbench for lpc_host. A reference model turns each
// transaction and target SYNC script into the expected per-cycle LAD/LFRAME#
// drive and the expected response; the bench replays the target side and
// compares every cycle.
module tb_lpc_host;
    import lpc_pkg::*;

    localparam int SYNC_TIMEOUT = 4;
    localparam int WAIT_MAX     = 255;

    logic       lpc_clock = 1'b0;
    logic       lpc_reset = 1'b0;
    lpc_state_t state;

    lpc_host_if bus ();

    lpc_host #(
        .SYNC_TIMEOUT (SYNC_TIMEOUT),
        .WAIT_MAX     (WAIT_MAX)
    ) dut (
        .lpc_clock (lpc_clock),
        .lpc_reset (lpc_reset),
        .bus       (bus),
        .state     (state)
    );

    // ---------------- clock ----------------
    always #5 lpc_clock = ~lpc_clock;

    // ---------------- scoreboard state ----------------
    int         total = 0;
    int         bad   = 0;
    logic [6:0] exp_q[$];        // {check_ad, frame, oe, ad} per cycle
    logic [3:0] adin_q[$];       // LAD value the target drives per cycle
    logic [3:0] sync_script[$];  // SYNC nibbles the target will offer

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit chk, input bit fr, input bit oe,
                        input logic [3:0] ad, input logic [3:0] ai);
        exp_q.push_back({chk, fr, oe, ad});
        adin_q.push_back(ai);
    endtask

    // Reference model: per-cycle bus expectations straight from the LPC
    // cycle layout and SYNC rules.
    task automatic build_model(input logic [3:0] cd, input logic [31:0] addr,
                               input logic [7:0] wd, input logic [7:0] td,
                               output logic e_err, output logic [7:0] e_rd);
        int waits = 0;
        int nones = 0;
        int nib;
        bit done = 0;
        bit aborted = 0;
        bit saw_err = 0;
        bit rd;
        exp_q.delete();
        adin_q.delete();
        e_err = 1'b0;
        e_rd  = 8'h00;
        if (cd[3:2] > 2'b01) begin
            e_err = 1'b1;
            return;
        end
        rd  = !cd[1];
        nib = (cd[3:2] == 2'b01) ? 8 : 4;
        push(1, 0, 1, 4'h0, 4'($urandom));
        push(1, 1, 1, cd, 4'($urandom));
        for (int i = nib - 1; i >= 0; i--) push(1, 1, 1, addr[4*i +: 4], 4'($urandom));
        if (!rd) begin
            push(1, 1, 1, wd[3:0], 4'($urandom));
            push(1, 1, 1, wd[7:4], 4'($urandom));
        end
        push(1, 1, 1, 4'hF, 4'($urandom));
        push(0, 1, 0, 4'h0, 4'($urandom));
        foreach (sync_script[i]) begin
            if (!done) begin
                push(0, 1, 0, 4'h0, sync_script[i]);
                case (sync_script[i])
                    4'h0: done = 1;
                    4'hA: begin done = 1; saw_err = 1; end
                    4'h5, 4'h6: begin
                        nones = 0;
                        waits++;
                        if (waits == WAIT_MAX) begin done = 1; aborted = 1; end
                    end
                    4'hF: begin
                        nones++;
                        if (nones == SYNC_TIMEOUT) begin done = 1; aborted = 1; end
                    end
                    default: begin done = 1; aborted = 1; end
                endcase
            end
        end
        if (aborted) begin
            for (int i = 0; i < 4; i++) push(1, 0, 1, 4'hF, 4'($urandom));
            e_err = 1'b1;
            e_rd  = 8'h00;
        end else begin
            if (rd) begin
                push(0, 1, 0, 4'h0, td[3:0]);
                push(0, 1, 0, 4'h0, td[7:4]);
            end
            push(0, 1, 0, 4'h0, 4'($urandom));
            push(0, 1, 0, 4'h0, 4'($urandom));
            e_err = saw_err;
            e_rd  = (rd && !saw_err) ? td : 8'h00;
        end
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge with the host idle; returns at a falling edge
    // one cycle after the response, host idle again.
    task automatic run_txn(input string name, input logic [3:0] cd, input logic [31:0] addr,
                           input logic [7:0] wd, input logic [7:0] td);
        logic       e_err;
        logic [7:0] e_rd;
        logic [6:0] e;
        int         n;
        build_model(cd, addr, wd, td, e_err, e_rd);
        n = exp_q.size();
        check({name, ".req_ready0"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid       = 1'b1;
        bus.req_cyctype_dir = cd;
        bus.req_addr        = addr;
        bus.req_wdata       = wd;
        @(posedge lpc_clock);
        #1;
        // scramble the request fields: they must have been latched
        bus.req_valid       = 1'b0;
        bus.req_cyctype_dir = 4'($urandom);
        bus.req_addr        = $urandom;
        bus.req_wdata       = 8'($urandom);
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            bus.lpc_ad_in = adin_q.pop_front();
            @(negedge lpc_clock);
            check($sformatf("%s.c%0d.frame", name, k + 1), 32'(bus.lpc_frame), 32'(e[5]));
            check($sformatf("%s.c%0d.oe", name, k + 1), 32'(bus.lpc_ad_oe), 32'(e[4]));
            if (e[6]) check($sformatf("%s.c%0d.ad", name, k + 1), 32'(bus.lpc_ad_out), 32'(e[3:0]));
            check($sformatf("%s.c%0d.rsp_valid", name, k + 1), 32'(bus.rsp_valid), 32'd0);
            check($sformatf("%s.c%0d.req_ready", name, k + 1), 32'(bus.req_ready), 32'd0);
            @(posedge lpc_clock);
            #1;
        end
        bus.lpc_ad_in = 4'($urandom);
        @(negedge lpc_clock);
        check($sformatf("%s.c%0d.rsp_valid", name, n + 1), 32'(bus.rsp_valid), 32'd1);
        check({name, ".rsp_error"}, 32'(bus.rsp_error), 32'(e_err));
        check({name, ".rsp_rdata"}, 32'(bus.rsp_rdata), 32'(e_rd));
        check({name, ".resp_frame"}, 32'(bus.lpc_frame), 32'd1);
        check({name, ".resp_oe"}, 32'(bus.lpc_ad_oe), 32'd0);
        @(posedge lpc_clock);
        #1;
        @(negedge lpc_clock);
        check({name, ".after_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({name, ".after_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic set_script_fill(input logic [3:0] code, input int cnt, input logic [3:0] last);
        sync_script.delete();
        for (int i = 0; i < cnt; i++) sync_script.push_back(code);
        sync_script.push_back(last);
    endtask

    function automatic logic [3:0] pick_code();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2)      return 4'h5;
        else if (r < 4) return 4'h6;
        else if (r < 8) return 4'hF;
        else if (r < 9) return 4'hA;
        else            return 4'($urandom);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] cd;
        bus.req_valid       = 1'b0;
        bus.req_cyctype_dir = 4'h0;
        bus.req_addr        = 32'h0;
        bus.req_wdata       = 8'h00;
        bus.lpc_ad_in       = 4'hF;

        // reset values
        #12;
        check("rst.frame", 32'(bus.lpc_frame), 32'd1);
        check("rst.oe", 32'(bus.lpc_ad_oe), 32'd0);
        check("rst.ad", 32'(bus.lpc_ad_out), 32'hF);
        check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst.rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rst.rsp_error", 32'(bus.rsp_error), 32'd0);
        check("rst.req_ready", 32'(bus.req_ready), 32'd1);
        check("rst.state", 32'(state), 32'(IDLE));
        @(negedge lpc_clock);
        lpc_reset = 1'b1;
        @(negedge lpc_clock);

        // directed cases
        set_script_fill(4'h0, 0, 4'h0);
        run_txn("iowr", 4'b0010, 32'h0000_0080, 8'hA5, 8'h00);
        set_script_fill(4'h5, 3, 4'h0);
        run_txn("memrd", 4'b0100, 32'hFFFF_FFF0, 8'h00, 8'h3C);
        set_script_fill(4'hF, 8, 4'h0);
        run_txn("iotmo", 4'b0000, 32'h0000_1234, 8'h00, 8'h77);
        set_script_fill(4'h0, 0, 4'hA);
        run_txn("ioerr", 4'b0010, 32'h0000_0060, 8'h5A, 8'h00);
        set_script_fill(4'h0, 0, 4'hA);
        run_txn("ioerr_rd", 4'b0000, 32'h0000_0064, 8'h00, 8'h99);
        set_script_fill(4'h0, 0, 4'h0);
        run_txn("dma", 4'b1000, 32'h0000_0004, 8'h11, 8'h00);
        sync_script = '{4'hF, 4'hF, 4'hF, 4'h6, 4'hF, 4'hF, 4'hF, 4'h0};
        run_txn("nonerst", 4'b0110, 32'h8000_0001, 8'hC3, 8'h00);
        sync_script = '{4'h5, 4'h3, 4'h0};
        run_txn("badsync", 4'b0000, 32'h0000_03F8, 8'h00, 8'h42);
        set_script_fill(4'h6, 254, 4'h0);
        run_txn("wait254", 4'b0000, 32'h0000_0070, 8'h00, 8'hE1);
        set_script_fill(4'h5, 260, 4'h0);
        run_txn("wait255", 4'b0100, 32'h0010_0000, 8'h00, 8'hE1);

        // reset in the middle of the address phase
        bus.req_valid       = 1'b1;
        bus.req_cyctype_dir = 4'b0010;
        bus.req_addr        = 32'h0000_0080;
        bus.req_wdata       = 8'h3E;
        @(posedge lpc_clock);
        #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge lpc_clock);
        #2;
        check("rstmid.pre_state", 32'(state), 32'(ADDR));
        lpc_reset = 1'b0;
        #1;
        check("rstmid.frame", 32'(bus.lpc_frame), 32'd1);
        check("rstmid.oe", 32'(bus.lpc_ad_oe), 32'd0);
        check("rstmid.req_ready", 32'(bus.req_ready), 32'd1);
        check("rstmid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge lpc_clock);
            check($sformatf("rstmid.hold%0d.rsp_valid", i), 32'(bus.rsp_valid), 32'd0);
        end
        lpc_reset = 1'b1;
        @(negedge lpc_clock);
        check("rstmid.post_valid", 32'(bus.rsp_valid), 32'd0);
        set_script_fill(4'h0, 0, 4'h0);
        run_txn("iowr2", 4'b0010, 32'h0000_0080, 8'hA5, 8'h00);

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 4))
                0: cd = 4'b0000;
                1: cd = 4'b0010;
                2: cd = 4'b0100;
                3: cd = 4'b0110;
                default: cd = 4'($urandom);
            endcase
            sync_script.delete();
            for (int i = 0; i < int'($urandom_range(0, 5)); i++) sync_script.push_back(pick_code());
            sync_script.push_back(($urandom_range(0, 5) == 0) ? 4'hA : 4'h0);
            run_txn($sformatf("rnd%0d", t), cd, $urandom, 8'($urandom), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lpc_host.md
Name: lpc_host

Overview:
- LPC initiator: turns single-request transactions (I/O or memory, read or write, 1 byte) into LPC 1.1 bus cycles on LAD[3:0]/LFRAME#.
- Handles SYNC waits, timeout and abort, then returns read data and status.
- Bus-side counterpart to the passive LPC decoder; used in the bench and as a host when no chipset is present.
- Pad tristate lives outside; this block provides out/oe/in separately.

Parameters:
- SYNC_TIMEOUT, 4: consecutive SYNC=1111 (no target) cycles before abort.
- WAIT_MAX, 255: max total short/long-wait SYNC cycles before abort.

Ports:
- lpc_clock  in  1  LPC clock; all logic on rising edge.
- lpc_reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; transfer when req_valid && req_ready.
- req_cyctype_dir  in  4  LPC CYCTYPE/DIR nibble: [3:2] 00=io, 01=mem; [1] 0=read, 1=write.
- req_addr  in  32  address; io uses [15:0].
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read data; valid with rsp_valid; 0 for writes and errors.
- rsp_error  out  1  with rsp_valid: error SYNC, timeout, wait overflow, or unsupported type.
- lpc_ad_out  out  4  LAD drive value.
- lpc_ad_oe  out  1  LAD output enable.
- lpc_ad_in  in  4  LAD sampled value.
- lpc_frame  out  1  LFRAME#, active low.

Behaviour:
- Reset (async assert, any state) forces:
  - lpc_frame=1, lpc_ad_oe=0, lpc_ad_out=1111.
  - rsp_valid=0, rsp_rdata=0, rsp_error=0, req_ready=1.
  - state=IDLE, counters 0.
  - An in-flight transaction is dropped with no response.
- Request registered at handshake edge E0. Cycle n means the clock period after edge En-1.
- Unsupported type ([3:2] not 00/01): no bus activity; rsp_valid=1, rsp_error=1 in cycle 1.
- States and drive (oe=1 unless noted):
  - IDLE: frame=1, oe=0.
  - START: 1 cycle, frame=0, ad=0000.
  - CYCDIR: 1 cycle, frame=1, ad=req_cyctype_dir.
  - ADDR: 4 nibbles (io) or 8 nibbles (mem), most-significant nibble first.
  - WDATA (write only): 2 cycles, low nibble then high nibble.
  - TAR: 2 cycles; ad=1111 with oe=1, then oe=0.
  - SYNC: oe=0; sample lpc_ad_in each cycle:
    - 0000: ready. Go to RDATA (read) or TAREND (write).
    - 0101/0110: wait. Increment wait counter; reaching WAIT_MAX goes to ABORT.
    - 1111: increment no-response counter; reaching SYNC_TIMEOUT goes to ABORT. Any other value clears this counter.
    - 1010: error. Continue as 0000, but rsp_error=1.
    - any other value: ABORT.
  - RDATA (read only): oe=0, 2 cycles capturing low nibble then high nibble into rsp_rdata.
  - TAREND: 2 cycles, oe=0 (target drives 1111, then floats).
  - RESP: 1 cycle, rsp_valid=1, then IDLE (req_ready=1 in the following cycle).
  - ABORT: frame=0, ad=1111, oe=1 for 4 cycles; then RESP with rsp_error=1 and rsp_rdata=0.
- Latency with immediate SYNC=0000, rsp_valid in cycle:
  - io read or io write: 14.
  - mem read or mem write: 18.
- Each wait cycle adds 1.
- Back-to-back: earliest next START is cycle 16 (io), because of the RESP and IDLE cycles.
- req_cyctype_dir, req_addr and req_wdata are latched at E0. Changes during a transaction are ignored.
- lpc_ad_in is ignored outside SYNC/RDATA.

Decomposition:
- Shared package lpc_pkg, used by both host and decoder:
  - state enum.
  - CYCTYPE constants (IO=00, MEM=01), DIR bit index.
  - SYNC codes (READY=0000, SHORT=0101, LONG=0110, ERR=1010, NONE=1111).
  - START=0000, ABORT=1111.
- Sub-module lpc_sync_eval:
  - Combinational SYNC classification plus both counters.
  - Outputs ready/err/abort to the main FSM.

Test Plan:
- io write 0x0080 data 0xA5, target SYNC 0000 -> LAD sequence 0000,0010,0,0,8,0,5,A,F,(Z),sync,Z,Z; rsp_valid in cycle 14, rsp_error=0.
- mem read 0xFFFFFFF0, target returns SYNC 0101x3 then 0000, data 0x3C (C then 3) -> rsp_rdata=0x3C, rsp_valid in cycle 21.
- io read, LAD floats at 1111 -> after 4 SYNC cycles, frame=0/ad=1111 for 4 cycles; rsp_valid with rsp_error=1, rsp_rdata=0.
- io write, target SYNC 1010 -> full cycle completes; rsp_error=1.
- req_cyctype_dir=1000 (DMA) -> frame stays 1, oe stays 0; rsp_valid+rsp_error in cycle 1.
- lpc_reset asserted in ADDR phase -> same cycle frame=1, oe=0, req_ready=1, no rsp_valid; next request after release runs normally.
